// File: rtl/dyser_pkg.sv
// Shared constants and helpers for the DySER processor-facing blocks.
package dyser_pkg;

  // Default payload width of a fabric result, in bits.
  localparam int DYSER_DATA_WIDTH = 64;

  // Default number of fabric output ports.
  localparam int DYSER_NUM_PORTS = 8;

  // Width of a port index carried by dyser_recv.
  localparam int PORT_IDX_W = 3;

  // Number of bits needed to hold an occupancy count of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : dyser_pkg

// File: rtl/dyser_out_fifo.sv
// Per-port result FIFO.
// Accepts one push per cycle when not full and retires 0, 1 or 2 entries per cycle.
// Exposes the head entry and the entry behind it so two lanes can read one port together.
module dyser_out_fifo
  import dyser_pkg::*;
#(
  parameter int DATA_WIDTH = DYSER_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [1:0]            pop_cnt,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [DATA_WIDTH-1:0] head1_data,
  output logic                  full,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_p1;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push_ok;

  // Full is judged on the registered count only. A pop in the same cycle does not free a slot early.
  assign full    = (count_q == CNT_W'(DEPTH));
  assign push_ok = push && !full;
  assign count   = count_q;

  // Both read ports are combinational from storage. There is no bypass from push_data.
  assign rd_ptr_p1  = rd_ptr_q + PTR_W'(1);
  assign head_data  = mem_q[rd_ptr_q];
  assign head1_data = mem_q[rd_ptr_p1];

  // Compute the next storage, pointers and count. DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (push_ok && (wr_ptr_q == PTR_W'(i))) begin
        mem_d[i] = push_data;
      end
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_cnt);
  end

  // State register. Reset clears storage so stale reads show zero until new data arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : dyser_out_fifo

// File: rtl/dyser_out_port_bank.sv
// Output port bank answering dyser_recv.
// Results from the fabric are buffered in one FIFO per output port.
// Two receive lanes read the buffered results by port number.
// Neither lane pops while any requested result is missing.
module dyser_out_port_bank
  import dyser_pkg::*;
#(
  parameter int DATA_WIDTH = DYSER_DATA_WIDTH,
  parameter int NUM_PORTS  = DYSER_NUM_PORTS,
  parameter int DEPTH      = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] fab_data,
  input  logic [NUM_PORTS-1:0]            fab_valid,
  output logic [NUM_PORTS-1:0]            fab_ready,
  input  logic [PORT_IDX_W-1:0]           recv_port_r0,
  input  logic [PORT_IDX_W-1:0]           recv_port_r1,
  input  logic                            recv_en0,
  input  logic                            recv_en1,
  output logic [DATA_WIDTH-1:0]           recv_data_r0,
  output logic [DATA_WIDTH-1:0]           recv_data_r1,
  output logic                            recv_stall
);

  localparam int CNT_W = cnt_width(DEPTH);

  logic [DATA_WIDTH-1:0] head      [NUM_PORTS];
  logic [DATA_WIDTH-1:0] head1     [NUM_PORTS];
  logic [CNT_W-1:0]      count     [NUM_PORTS];
  logic [1:0]            need      [NUM_PORTS];
  logic [1:0]            pop_cnt   [NUM_PORTS];
  logic [NUM_PORTS-1:0]  full;
  logic [NUM_PORTS-1:0]  short_vec;
  logic                  same_port;

  // Both lanes name one port. Lane 1 then takes the entry behind lane 0's.
  assign same_port = recv_en0 && recv_en1 && (recv_port_r0 == recv_port_r1);

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic hit0;
    logic hit1;

    // Count the lanes that want this port. The count is 0, 1 or 2.
    assign hit0     = recv_en0 && (recv_port_r0 == PORT_IDX_W'(gi));
    assign hit1     = recv_en1 && (recv_port_r1 == PORT_IDX_W'(gi));
    assign need[gi] = {1'b0, hit0} + {1'b0, hit1};

    // This port holds fewer results than the lanes asked for.
    assign short_vec[gi] = (count[gi] < CNT_W'(need[gi]));

    // A stall on any port holds back both lanes, so no request ever completes partially.
    assign pop_cnt[gi] = recv_stall ? 2'd0 : need[gi];

    assign fab_ready[gi] = ~full[gi];

    dyser_out_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .CNT_W      (CNT_W)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (fab_valid[gi]),
      .push_data  (fab_data[gi*DATA_WIDTH +: DATA_WIDTH]),
      .pop_cnt    (pop_cnt[gi]),
      .head_data  (head[gi]),
      .head1_data (head1[gi]),
      .full       (full[gi]),
      .count      (count[gi])
    );
  end

  assign recv_stall = |short_vec;

  // Lane data mux. A missing entry shows whatever is stored in that slot.
  always_comb begin
    recv_data_r0 = head[recv_port_r0];
    recv_data_r1 = head[recv_port_r1];
    if (same_port) begin
      recv_data_r1 = head1[recv_port_r1];
    end
  end

endmodule : dyser_out_port_bank

// File: tb/tb_dyser_out_port_bank.sv
// Self-checking bench for dyser_out_port_bank.
// The reference model keeps one SystemVerilog queue per port.
module tb_dyser_out_port_bank;

  localparam int DW    = 64;
  localparam int NP    = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP*DW-1:0] fab_data;
  logic [NP-1:0]    fab_valid;
  logic [NP-1:0]    fab_ready;
  logic [2:0]       recv_port_r0, recv_port_r1;
  logic             recv_en0, recv_en1;
  logic [DW-1:0]    recv_data_r0, recv_data_r1;
  logic             recv_stall;

  // Per-port payloads that the next cycle presents to the fabric inputs.
  logic [DW-1:0]    fd [NP];
  // Reference model: one ordered queue of pending results per port.
  logic [DW-1:0]    mq [NP][$];

  int errors = 0;
  int checks = 0;

  dyser_out_port_bank #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .fab_data     (fab_data),
    .fab_valid    (fab_valid),
    .fab_ready    (fab_ready),
    .recv_port_r0 (recv_port_r0),
    .recv_port_r1 (recv_port_r1),
    .recv_en0     (recv_en0),
    .recv_en1     (recv_en1),
    .recv_data_r0 (recv_data_r0),
    .recv_data_r1 (recv_data_r1),
    .recv_stall   (recv_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Run one clock. Drive at negedge, check the outputs against the model, then advance the model at posedge.
  task automatic cycle(input logic r, input logic [NP-1:0] v,
                       input logic e0, input logic [2:0] q0,
                       input logic e1, input logic [2:0] q1,
                       input string tag);
    int            need [NP];
    logic [NP-1:0] rdy;
    logic          stl;
    logic [DW-1:0] exp1;
    @(negedge clk);
    rst = r;
    fab_valid = v;
    recv_en0 = e0;
    recv_port_r0 = q0;
    recv_en1 = e1;
    recv_port_r1 = q1;
    for (int p = 0; p < NP; p++) fab_data[p*DW +: DW] = fd[p];
    #1;
    stl = 1'b0;
    for (int p = 0; p < NP; p++) need[p] = 0;
    if (e0) need[q0]++;
    if (e1) need[q1]++;
    for (int p = 0; p < NP; p++) begin
      rdy[p] = (mq[p].size() != DEPTH);
      if (mq[p].size() < need[p]) stl = 1'b1;
    end
    check({tag, ".ready"}, DW'(fab_ready), DW'(rdy));
    check({tag, ".stall"}, DW'(recv_stall), DW'(stl));
    if (!stl && e0) check({tag, ".r0"}, recv_data_r0, mq[q0][0]);
    if (!stl && e1) begin
      exp1 = (e0 && q0 == q1) ? mq[q1][1] : mq[q1][0];
      check({tag, ".r1"}, recv_data_r1, exp1);
    end
    @(posedge clk);
    if (r) begin
      for (int p = 0; p < NP; p++) mq[p].delete();
    end else begin
      if (!stl && e0) void'(mq[q0].pop_front());
      if (!stl && e1) void'(mq[q1].pop_front());
      for (int p = 0; p < NP; p++)
        if (v[p] && rdy[p]) mq[p].push_back(fd[p]);
    end
  endtask

  initial begin
    rst = 1'b1;
    fab_valid = '0;
    fab_data = '0;
    recv_en0 = 1'b0;
    recv_en1 = 1'b0;
    recv_port_r0 = '0;
    recv_port_r1 = '0;
    for (int p = 0; p < NP; p++) fd[p] = '0;

    // Reset then idle.
    cycle(1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, "reset");
    @(negedge clk); #1;
    check("rst_ready", DW'(fab_ready), DW'(8'hFF));
    check("rst_stall", DW'(recv_stall), '0);
    check("rst_r0", recv_data_r0, '0);
    check("rst_r1", recv_data_r1, '0);
    cycle(1'b0, 8'h00, 1'b1, 3'd3, 1'b0, 3'd0, "empty_p3");
    cycle(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, "idle");

    // Single push and pop. The request in the push cycle stalls, then completes the next cycle.
    fd[5] = 64'hA;
    cycle(1'b0, 8'h20, 1'b1, 3'd5, 1'b0, 3'd0, "p5_push");
    fd[5] = '0;
    cycle(1'b0, 8'h00, 1'b1, 3'd5, 1'b0, 3'd0, "p5_pop");
    cycle(1'b0, 8'h00, 1'b1, 3'd5, 1'b0, 3'd0, "p5_empty");

    // Both lanes read different ports in one cycle.
    fd[1] = 64'h5; fd[0] = 64'hF;
    cycle(1'b0, 8'h03, 1'b0, 3'd0, 1'b0, 3'd0, "dual_fill");
    cycle(1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 3'd0, "dual_pop");
    cycle(1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 3'd0, "dual_empty");

    // Double pop from one port, then a double request with only one entry present.
    fd[2] = 64'hD;
    cycle(1'b0, 8'h04, 1'b0, 3'd0, 1'b0, 3'd0, "dbl_fill0");
    fd[2] = 64'h11;
    cycle(1'b0, 8'h04, 1'b0, 3'd0, 1'b0, 3'd0, "dbl_fill1");
    cycle(1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 3'd2, "dbl_pop");
    fd[2] = 64'h77;
    cycle(1'b0, 8'h04, 1'b0, 3'd0, 1'b0, 3'd0, "dbl_fill2");
    cycle(1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 3'd2, "dbl_short");
    cycle(1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 3'd0, "dbl_single");

    // Fill port 4 to full. The fifth value waits, stays refused through the first pop, then enters.
    for (int k = 1; k <= 4; k++) begin
      fd[4] = DW'(k);
      cycle(1'b0, 8'h10, 1'b0, 3'd0, 1'b0, 3'd0, "full_fill");
    end
    fd[4] = 64'd5;
    cycle(1'b0, 8'h10, 1'b0, 3'd0, 1'b0, 3'd0, "full_hold");
    cycle(1'b0, 8'h10, 1'b1, 3'd4, 1'b0, 3'd0, "full_pop1");
    cycle(1'b0, 8'h10, 1'b1, 3'd4, 1'b0, 3'd0, "full_accept");
    cycle(1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 3'd4, "full_pop34");
    cycle(1'b0, 8'h00, 1'b1, 3'd4, 1'b0, 3'd0, "full_pop5");
    cycle(1'b0, 8'h00, 1'b1, 3'd4, 1'b0, 3'd0, "full_empty");

    // Reset during operation: partially filled ports and a stalled request.
    for (int p = 0; p < NP; p++) fd[p] = {$urandom, $urandom};
    cycle(1'b0, 8'hFE, 1'b0, 3'd0, 1'b0, 3'd0, "mid_fill");
    cycle(1'b0, 8'h5A, 1'b1, 3'd0, 1'b1, 3'd1, "mid_stall");
    cycle(1'b1, 8'hFF, 1'b1, 3'd0, 1'b1, 3'd1, "mid_rst");
    @(negedge clk); #1;
    check("midrst_ready", DW'(fab_ready), DW'(8'hFF));
    check("midrst_stall", DW'(recv_stall), 64'd1);
    check("midrst_r0", recv_data_r0, '0);
    check("midrst_r1", recv_data_r1, '0);
    cycle(1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 3'd0, "post_stall");
    fd[1] = 64'h99;
    cycle(1'b0, 8'h02, 1'b1, 3'd1, 1'b0, 3'd0, "post_push");
    cycle(1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 3'd0, "post_pop");

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      logic [NP-1:0] v;
      logic          e0, e1, r;
      logic [2:0]    a0, a1;
      for (int p = 0; p < NP; p++) fd[p] = {$urandom, $urandom};
      v  = NP'($urandom & $urandom);
      e0 = ($urandom_range(0, 2) != 0);
      e1 = ($urandom_range(0, 2) != 0);
      a0 = 3'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 3'($urandom_range(0, 7));
      r  = ($urandom_range(0, 199) == 0);
      cycle(r, v, e0, a0, e1, a1, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dyser_out_port_bank

// File: doc/dyser_out_port_bank.md
Name: dyser_out_port_bank

Overview:
- Processor-facing responder for dyser_recv.
- Buffers results leaving the DySER fabric in one small FIFO per output port.
- Serves up to two receive requests per cycle (lanes r0/r1) by port number.
- Asserts recv_stall when a requested result is not yet available.
- Sits between the fabric output switches and the pipeline's recv_data_r0/r1 writeback path.

Parameters:
- DATA_WIDTH, 64: payload width in bits. Buses are [DATA_WIDTH-1:0], matching the existing [`DATA_WIDTH:0] convention with `DATA_WIDTH=63.
- NUM_PORTS, 8: number of fabric output ports. Port index is 3 bits.
- DEPTH, 4: entries per port FIFO. Must be a power of two and at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- fab_data  in  NUM_PORTS*DATA_WIDTH  per-port result from fabric; port p occupies slice [p*DATA_WIDTH +: DATA_WIDTH].
- fab_valid  in  NUM_PORTS  per-port result valid.
- fab_ready  out  NUM_PORTS  per-port accept (FIFO not full).
- recv_port_r0  in  3  lane-0 requested port.
- recv_port_r1  in  3  lane-1 requested port.
- recv_en0  in  1  lane-0 request.
- recv_en1  in  1  lane-1 request.
- recv_data_r0  out  DATA_WIDTH  lane-0 result.
- recv_data_r1  out  DATA_WIDTH  lane-1 result.
- recv_stall  out  1  request cannot complete this cycle.

Behaviour:
- Reset (synchronous, active-high, rst sampled at posedge clk):
  - All FIFOs empty; pointers and counts cleared; storage zeroed.
  - fab_ready = all ones; recv_data_r0/r1 = 0; recv_stall = 0 while no enable is high.
  - rst dominates any simultaneous push or pop.
- Fabric push:
  - Port p writes fab_data slice p at posedge when fab_valid[p] && fab_ready[p].
  - fab_ready[p] = (count[p] != DEPTH), derived combinationally from registered count. A full FIFO never accepts, even when a pop occurs in the same cycle.
  - Valid without ready holds: the fabric keeps data stable, and this block imposes no timeout.
- Receive (combinational read, no bypass):
  - recv_data_r0 = head of FIFO[recv_port_r0].
  - If both lanes are enabled and target the same port, recv_data_r1 = head+1 of that FIFO; otherwise recv_data_r1 = head of FIFO[recv_port_r1].
  - When a selected entry does not exist, the data output shows the stale storage value.
  - need[p] = number of enabled lanes targeting p (0..2).
  - recv_stall = 1 if any p has count[p] < need[p].
  - Stall is all-or-nothing: no pop occurs on either lane while recv_stall = 1.
  - When recv_stall = 0, each enabled lane pops at posedge; a same-port double request pops 2.
- Simultaneous events:
  - Push and pop on the same port in one cycle: count += pushes − pops. Pointers wrap modulo DEPTH.
  - A value pushed at edge N is readable after edge N, never in the cycle it is presented. A request against an empty port that receives a push therefore completes one cycle later.
  - recv_en low on both lanes: recv_stall = 0 and no pops.
- Ordering: per-port FIFO order is strict; there is no cross-port ordering.
- Timing: single-cycle throughput per lane. Latency fabric-valid → readable is 1 cycle.

Decomposition:
- Add to dyser_pkg:
  - DATA_WIDTH and NUM_PORTS defaults.
  - PORT_IDX_W = 3.
  - A function returning the count width for a given DEPTH.
- Sub-module dyser_out_fifo, one instance per port:
  - push, 0–2 pops per cycle, head and head+1 read ports, full/count outputs.
- Top level contains lane decode, need/stall logic and data muxing.

Test Plan:
- Reset then idle: after rst, fab_ready = 8'hFF, recv_stall = 0, recv_data_r0 = 0; recv_en0 on port 3 alone → recv_stall = 1, no pop.
- Single push/pop: fab port 5 pushes 64'hA at edge N; lane0 requests port 5 in cycle N (stall = 1), then cycle N+1 → recv_data_r0 = 64'hA, stall = 0; FIFO empty afterwards.
- Dual lanes, different ports: port1 holds 64'h5, port0 holds 64'hF; both lanes request in one cycle → r0 = 64'h5, r1 = 64'hF, no stall, both ports empty next cycle.
- Same port double pop: port 2 holds 64'hD, 64'h11; both lanes request port 2 → r0 = 64'hD, r1 = 64'h11, count 0. With only one entry present → recv_stall = 1 and count remains 1.
- Full/backpressure: push 4 values to port 4 → fab_ready[4] = 0. A 5th valid is held until one lane pop, then accepted next edge. Read-out order is exact (1, 2, 3, 4, 5) and pointers wrap correctly.
- Reset mid-operation: ports 0–7 partially filled and lanes stalled; rst for 1 cycle → all counts 0, fab_ready all ones, pending requests stall until new data arrives.
